// File: rtl/mips_cache_pkg.sv
// Shared types and address-width helpers for the MIPS data cache.
package mips_cache_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      WRITE = 2'd2
   } dcache_state_t;

   function automatic int unsigned wo_bits(input int unsigned block_words);
      return $clog2(block_words);
   endfunction

   function automatic int unsigned ix_bits(input int unsigned num_lines);
      return $clog2(num_lines);
   endfunction

   function automatic int unsigned tag_bits(input int unsigned num_lines,
                                            input int unsigned block_words);
      return 30 - ix_bits(num_lines) - wo_bits(block_words);
   endfunction

   // Word counter keeps at least one bit so single-word lines still have a legal vector.
   function automatic int unsigned cnt_bits(input int unsigned block_words);
      return (wo_bits(block_words) > 0) ? wo_bits(block_words) : 1;
   endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag/valid/data storage: one combinational read port, one synchronous write port.
module dcache_array
   import mips_cache_pkg::*;
#(
   parameter int unsigned NUM_LINES   = 64,
   parameter int unsigned BLOCK_WORDS = 4,
   localparam int unsigned WO = wo_bits(BLOCK_WORDS),
   localparam int unsigned IX = ix_bits(NUM_LINES),
   localparam int unsigned TW = tag_bits(NUM_LINES, BLOCK_WORDS),
   localparam int unsigned CW = cnt_bits(BLOCK_WORDS)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [IX-1:0] rd_index,
   input  logic [CW-1:0] rd_word,
   output logic          rd_valid,
   output logic [TW-1:0] rd_tag,
   output logic [31:0]   rd_data,
   input  logic          wr_en,
   input  logic [IX-1:0] wr_index,
   input  logic [CW-1:0] wr_word,
   input  logic [31:0]   wr_data,
   input  logic          tag_we,
   input  logic [TW-1:0] tag_wdata
);

   localparam int unsigned PW = IX + WO;

   logic [NUM_LINES-1:0] valid_q;
   logic [TW-1:0]        tags [NUM_LINES];
   logic [31:0]          data_mem [NUM_LINES*BLOCK_WORDS];
   logic [PW-1:0]        rd_ptr;
   logic [PW-1:0]        wr_ptr;

   if (WO > 0) begin : g_multi_word
      assign rd_ptr = {rd_index, rd_word};
      assign wr_ptr = {wr_index, wr_word};
   end else begin : g_single_word
      assign rd_ptr = rd_index;
      assign wr_ptr = wr_index;
   end

   assign rd_valid = valid_q[rd_index];
   assign rd_tag   = tags[rd_index];
   assign rd_data  = data_mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
      end else if (tag_we) begin
         valid_q[wr_index] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         data_mem[wr_ptr] <= wr_data;
      end
      if (tag_we) begin
         tags[wr_index] <= tag_wdata;
      end
   end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-through, no-write-allocate data cache controller.
// Optional DCACHE_STATS_EN adds hit_count/miss_count outputs.
module dcache_ctrl
   import mips_cache_pkg::*;
#(
   parameter int unsigned NUM_LINES   = 64,
   parameter int unsigned BLOCK_WORDS = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cpu_re,
   input  logic        cpu_we,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic [31:0] cpu_rdata,
   output logic        cpu_stall,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack
`ifdef DCACHE_STATS_EN
   ,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count
`endif
);

   localparam int unsigned WO = wo_bits(BLOCK_WORDS);
   localparam int unsigned IX = ix_bits(NUM_LINES);
   localparam int unsigned TW = tag_bits(NUM_LINES, BLOCK_WORDS);
   localparam int unsigned CW = cnt_bits(BLOCK_WORDS);

   dcache_state_t state_q;
   logic [CW-1:0] cnt_q;
   logic [31:0]   addr_q;
   logic          done_q;

   logic [31:0]   lookup_addr;
   logic [31:0]   word_addr;
   logic [IX-1:0] lk_index;
   logic [CW-1:0] lk_word;
   logic [TW-1:0] lk_tag;
   logic          rd_valid;
   logic [TW-1:0] rd_tag;
   logic          hit;
   logic          store_start;
   logic          read_miss;
   logic          fill_last;
   logic          wr_en;
   logic          tag_we;
   logic [CW-1:0] wr_word;
   logic [31:0]   wr_data;

   // While busy, the lookup port follows the latched address so WRITE can test for a hit.
   always_comb begin
      lookup_addr = (state_q == IDLE) ? cpu_addr : addr_q;
      word_addr   = lookup_addr >> 2;
      lk_word     = CW'(word_addr & (BLOCK_WORDS - 1));
      lk_index    = IX'(word_addr >> WO);
      lk_tag      = TW'(word_addr >> (WO + IX));
   end

   assign hit         = rd_valid && (rd_tag == lk_tag);
   // done_q marks the cycle after a store ack, when the frozen core still holds cpu_we.
   assign store_start = (state_q == IDLE) && cpu_we && !done_q;
   assign read_miss   = (state_q == IDLE) && cpu_re && !cpu_we && !hit;
   assign cpu_stall   = (cpu_re || cpu_we) && ((state_q != IDLE) || store_start || read_miss);
   assign fill_last   = (cnt_q == CW'(BLOCK_WORDS - 1));

   always_comb begin
      wr_en   = mem_ack && ((state_q == FILL) || ((state_q == WRITE) && hit));
      tag_we  = mem_ack && (state_q == FILL) && fill_last;
      wr_word = (state_q == FILL) ? cnt_q : lk_word;
      wr_data = (state_q == FILL) ? mem_rdata : mem_wdata;
   end

   dcache_array #(
      .NUM_LINES   (NUM_LINES),
      .BLOCK_WORDS (BLOCK_WORDS)
   ) u_array (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_index  (lk_index),
      .rd_word   (lk_word),
      .rd_valid  (rd_valid),
      .rd_tag    (rd_tag),
      .rd_data   (cpu_rdata),
      .wr_en     (wr_en),
      .wr_index  (lk_index),
      .wr_word   (wr_word),
      .wr_data   (wr_data),
      .tag_we    (tag_we),
      .tag_wdata (lk_tag)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         addr_q    <= '0;
         done_q    <= 1'b0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (store_start) begin
                  state_q   <= WRITE;
                  addr_q    <= cpu_addr;
                  mem_req   <= 1'b1;
                  mem_we    <= 1'b1;
                  mem_addr  <= cpu_addr & ~32'd3;
                  mem_wdata <= cpu_wdata;
               end else if (read_miss) begin
                  state_q  <= FILL;
                  addr_q   <= cpu_addr;
                  cnt_q    <= '0;
                  mem_req  <= 1'b1;
                  mem_we   <= 1'b0;
                  mem_addr <= cpu_addr & ~(BLOCK_WORDS * 4 - 1);
               end
            end
            FILL: begin
               if (mem_ack) begin
                  if (fill_last) begin
                     state_q <= IDLE;
                     cnt_q   <= '0;
                     mem_req <= 1'b0;
                  end else begin
                     cnt_q    <= cnt_q + CW'(1);
                     mem_addr <= mem_addr + 32'd4;
                  end
               end
            end
            WRITE: begin
               if (mem_ack) begin
                  state_q <= IDLE;
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef DCACHE_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         if ((state_q == IDLE) && cpu_re && !cpu_we && hit) begin
            hit_count <= hit_count + 32'd1;
         end
         if (read_miss) begin
            miss_count <= miss_count + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl with a fixed-latency memory and a residency/memory model.
module tb_dcache_ctrl;

   localparam int unsigned NL  = 64;
   localparam int unsigned BW  = 4;
   localparam int unsigned LAT = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cpu_re = 1'b0;
   logic        cpu_we = 1'b0;
   logic [31:0] cpu_addr = '0;
   logic [31:0] cpu_wdata = '0;
   logic [31:0] cpu_rdata;
   logic        cpu_stall;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = '0;
   logic        mem_ack = 1'b0;
`ifdef DCACHE_STATS_EN
   logic [31:0] hit_count;
   logic [31:0] miss_count;
`endif

   int total = 0;
   int bad = 0;

   typedef struct {
      bit        we;
      bit [31:0] addr;
      bit [31:0] data;
   } xact_t;

   xact_t       log_q[$];
   bit [31:0]   mem [bit [31:0]];
   bit          res_valid [NL];
   bit [31:0]   res_tag [NL];
   int unsigned exp_hits = 0;
   int unsigned exp_misses = 0;

   dcache_ctrl #(
      .NUM_LINES   (NL),
      .BLOCK_WORDS (BW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cpu_re    (cpu_re),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_rdata (cpu_rdata),
      .cpu_stall (cpu_stall),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack)
`ifdef DCACHE_STATS_EN
      ,
      .hit_count  (hit_count),
      .miss_count (miss_count)
`endif
   );

   always #5 clk = ~clk;

   function automatic bit [31:0] mem_val(input bit [31:0] a);
      if (mem.exists(a)) return mem[a];
      return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
   endfunction

   // Memory: each request is acked in its LAT-th cycle of mem_req high.
   initial begin
      int cnt;
      cnt = 0;
      forever begin
         @(posedge clk);
         #1;
         if (mem_ack) begin
            mem_ack = 1'b0;
            cnt = 0;
         end
         if (mem_req && rst_n) begin
            cnt++;
            if (cnt == LAT) begin
               xact_t x;
               x.we   = mem_we;
               x.addr = mem_addr;
               x.data = mem_we ? mem_wdata : mem_val(mem_addr);
               if (mem_we) mem[mem_addr] = mem_wdata;
               else mem_rdata = x.data;
               log_q.push_back(x);
               mem_ack = 1'b1;
            end
         end else begin
            cnt = 0;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
      $fatal(1, "watchdog");
   end

   function automatic void model_reset();
      for (int i = 0; i < NL; i++) res_valid[i] = 1'b0;
      exp_hits = 0;
      exp_misses = 0;
   endfunction

   // Called at +2 of a cycle; returns at +2 of the cycle after the load completes.
   task automatic do_load(input bit [31:0] addr, output bit [31:0] got, output bit missed);
      bit [31:0] a, tag, base, exp_data;
      int        idx, stalls, exp_stalls;
      bit        hit, req_at_start, ok;
      a     = addr & ~32'd3;
      base  = a & ~32'hF;
      idx   = int'((a >> 4) % NL);
      tag   = a >> 10;
      hit   = res_valid[idx] && (res_tag[idx] == tag);
      exp_data = mem_val(a);
      log_q.delete();
      cpu_re = 1'b1;
      cpu_we = 1'b0;
      cpu_addr = addr;
      #1;
      req_at_start = mem_req;
      stalls = 0;
      while (cpu_stall && stalls < 500) begin
         stalls++;
         @(posedge clk);
         #3;
      end
      total++;
      if (cpu_stall !== 1'b0) begin
         bad++;
         $display("FAIL load_timeout addr=%h stall=%b want 0", addr, cpu_stall);
      end
      // Miss: the request cycle plus LAT cycles for each word of the line.
      exp_stalls = hit ? 0 : 1 + LAT * BW;
      total++;
      if (stalls !== exp_stalls) begin
         bad++;
         $display("FAIL load_stall_cycles addr=%h got=%0d want=%0d", addr, stalls, exp_stalls);
      end
      total++;
      if (cpu_rdata !== exp_data) begin
         bad++;
         $display("FAIL load_data addr=%h got=%h want=%h", addr, cpu_rdata, exp_data);
      end
      ok = 1'b1;
      if (hit) begin
         if (log_q.size() != 0 || req_at_start !== 1'b0) ok = 1'b0;
      end else begin
         if (log_q.size() != BW) ok = 1'b0;
         else for (int k = 0; k < BW; k++)
            if (log_q[k].we || log_q[k].addr != base + 32'(4 * k)) ok = 1'b0;
      end
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL load_mem_traffic addr=%h got=%0d xacts req=%b want %0d reads from %h",
                  addr, log_q.size(), req_at_start, hit ? 0 : BW, base);
      end
      if (!hit) begin
         res_valid[idx] = 1'b1;
         res_tag[idx] = tag;
         exp_misses++;
      end
      exp_hits++;
      got = cpu_rdata;
      missed = (stalls != 0);
      @(posedge clk);
      #2;
      cpu_re = 1'b0;
   endtask

   task automatic do_store(input bit [31:0] addr, input bit [31:0] data, input bit with_re);
      int stalls;
      bit ok;
      log_q.delete();
      cpu_we = 1'b1;
      cpu_re = with_re;
      cpu_addr = addr;
      cpu_wdata = data;
      #1;
      stalls = 0;
      while (cpu_stall && stalls < 500) begin
         stalls++;
         @(posedge clk);
         #3;
      end
      total++;
      if (stalls !== 1 + LAT) begin
         bad++;
         $display("FAIL store_stall_cycles addr=%h got=%0d want=%0d", addr, stalls, 1 + LAT);
      end
      ok = (log_q.size() == 1) && log_q[0].we && (log_q[0].addr == (addr & ~32'd3))
           && (log_q[0].data == data);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL store_mem_traffic addr=%h got=%0d xacts want one write of %h",
                  addr, log_q.size(), data);
      end
      @(posedge clk);
      #2;
      cpu_we = 1'b0;
      cpu_re = 1'b0;
   endtask

   task automatic test_reset();
      #12;
      total++;
      if (mem_req !== 1'b0 || mem_we !== 1'b0) begin
         bad++;
         $display("FAIL reset_req req=%b we=%b want 0 0", mem_req, mem_we);
      end
      total++;
      if (mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin
         bad++;
         $display("FAIL reset_bus addr=%h wdata=%h want 0 0", mem_addr, mem_wdata);
      end
      total++;
      if (cpu_stall !== 1'b0) begin
         bad++;
         $display("FAIL reset_stall got=%b want 0", cpu_stall);
      end
      rst_n = 1'b1;
      model_reset();
      @(posedge clk);
      #2;
   endtask

   task automatic test_fill();
      bit [31:0] got;
      bit missed;
      do_load(32'h40, got, missed);
      total++;
      if (missed !== 1'b1) begin
         bad++;
         $display("FAIL fill_first_miss got_missed=%b want 1", missed);
      end
   endtask

   task automatic test_hit();
      bit [31:0] got;
      bit missed;
      do_load(32'h4C, got, missed);
      total++;
      if (missed !== 1'b0) begin
         bad++;
         $display("FAIL hit_same_line got_missed=%b want 0", missed);
      end
`ifdef DCACHE_STATS_EN
      total++;
      if (hit_count !== 32'd2 || miss_count !== 32'd1) begin
         bad++;
         $display("FAIL stats_after_hit hit=%0d miss=%0d want 2 1", hit_count, miss_count);
      end
`endif
   endtask

   task automatic test_store_hit();
      bit [31:0] got;
      bit missed;
      do_store(32'h44, 32'hDEAD_BEEF, 1'b0);
      do_load(32'h44, got, missed);
      total++;
      if (got !== 32'hDEAD_BEEF || missed !== 1'b0) begin
         bad++;
         $display("FAIL store_hit_readback got=%h missed=%b want deadbeef 0", got, missed);
      end
   endtask

   task automatic test_store_miss();
      bit [31:0] got;
      bit missed;
      do_store(32'h1000, 32'h1234_5678, 1'b0);
      do_load(32'h1000, got, missed);
      total++;
      if (got !== 32'h1234_5678 || missed !== 1'b1) begin
         bad++;
         $display("FAIL store_miss_no_alloc got=%h missed=%b want 12345678 1", got, missed);
      end
   endtask

   task automatic test_conflict();
      bit [31:0] got;
      bit m1, m2, m3;
      do_load(32'h40, got, m1);
      do_load(32'h440, got, m2);
      do_load(32'h40, got, m3);
      total++;
      if (m2 !== 1'b1 || m3 !== 1'b1) begin
         bad++;
         $display("FAIL conflict_evict missed=%b%b want 11", m2, m3);
      end
   endtask

   task automatic test_both();
      bit [31:0] got, v;
      bit missed;
      v = $urandom;
      do_store(32'h48, v, 1'b1);
      do_load(32'h48, got, missed);
      total++;
      if (got !== v) begin
         bad++;
         $display("FAIL both_store_wins got=%h want %h", got, v);
      end
   endtask

   task automatic test_reset_mid_fill();
      bit [31:0] got;
      bit missed;
      int n;
      log_q.delete();
      cpu_re = 1'b1;
      cpu_addr = 32'h840;
      n = 0;
      while (log_q.size() < 2 && n < 100) begin
         @(posedge clk);
         #3;
         n++;
      end
      total++;
      if (log_q.size() < 2) begin
         bad++;
         $display("FAIL midfill_acks got=%0d want 2", log_q.size());
      end
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if (mem_req !== 1'b0) begin
         bad++;
         $display("FAIL midfill_req_drop got=%b want 0", mem_req);
      end
      cpu_re = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      model_reset();
      do_load(32'h40, got, missed);
      total++;
      if (missed !== 1'b1) begin
         bad++;
         $display("FAIL midfill_refill got_missed=%b want 1", missed);
      end
      do_load(32'h844, got, missed);
   endtask

   task automatic test_random();
      bit [31:0] a, got;
      bit missed;
      for (int i = 0; i < 150; i++) begin
         a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 7)) << 4)
             | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
         if ($urandom_range(0, 9) < 7) do_load(a, got, missed);
         else do_store(a, $urandom, 1'($urandom_range(0, 1)));
      end
`ifdef DCACHE_STATS_EN
      total++;
      if (hit_count !== exp_hits || miss_count !== exp_misses) begin
         bad++;
         $display("FAIL stats_random hit=%0d miss=%0d want %0d %0d",
                  hit_count, miss_count, exp_hits, exp_misses);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_fill();
      test_hit();
      test_store_hit();
      test_store_miss();
      test_conflict();
      test_both();
      test_reset_mid_fill();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
